// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/ERET commit controller. Drives CP0 write enables,
// pipeline flush and the fetch redirect, all from registered outputs.
module exc_ctrl #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_pc,
    input  logic             mem_in_delay_slot,
    input  logic             exc_adel_if,
    input  logic             exc_ri,
    input  logic             exc_ov,
    input  logic             exc_sys,
    input  logic             exc_bp,
    input  logic             exc_adel_mem,
    input  logic             exc_ades,
    input  logic             is_eret,
    input  logic [WIDTH-1:0] mem_badaddr,
    input  logic [5:0]       hw_int,
    input  logic             timer_int,
    input  logic [WIDTH-1:0] Status_data,
    input  logic [WIDTH-1:0] cause_data,
    input  logic [WIDTH-1:0] EPC_data,
    output logic [WIDTH-1:0] we,
    output logic [WIDTH-1:0] BADADDR,
    output logic [WIDTH-1:0] epc,
    output logic             Branch_delay,
    output logic [4:0]       Exception_code,
    output logic [5:0]       hardware_interruption,
    output logic [7:0]       interrupt_enable,
    output logic             EXL,
    output logic             IE,
    output logic             flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
);
    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [5:0]       sync1_q, sync2_q;
    logic [WIDTH-1:0] we_q, we_d, badaddr_q, badaddr_d, epc_q, epc_d, rpc_q, rpc_d;
    logic             bd_q, bd_d, exl_q, exl_d, ie_q, ie_d, flush_q, flush_d, rv_q, rv_d;
    logic [4:0]       code_q, code_d, code;
    logic [7:0]       ien_q, ien_d;
    logic             int_pend, is_exc, accept, addr_err;
    logic             unused;

    assign unused = ^{Status_data[WIDTH-1:16], Status_data[7:2], cause_data[WIDTH-1:10], cause_data[7:0]};

    always_comb begin
        int_pend = Status_data[0] & ~Status_data[1] & |(Status_data[15:8] & {sync2_q, cause_data[9:8]});
        is_exc   = int_pend | exc_adel_if | exc_ri | exc_ov | exc_sys | exc_bp | exc_adel_mem | exc_ades;
        accept   = (state_q == IDLE) && mem_valid && (is_exc || is_eret);
        code     = int_pend     ? 5'd0  :
                   exc_adel_if  ? 5'd4  :
                   exc_ri       ? 5'd10 :
                   exc_ov       ? 5'd12 :
                   exc_sys      ? 5'd8  :
                   exc_bp       ? 5'd9  :
                   exc_adel_mem ? 5'd4  : 5'd5;
        addr_err = (code == 5'd4) || (code == 5'd5);
        state_d  = state_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE:   if (accept) state_d = COMMIT;
            COMMIT: if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else state_d = IDLE;
            default: begin
                        cnt_d   = cnt_q - 3'd1;
                        state_d = (cnt_q <= 3'd1) ? IDLE : FLUSH;
                    end
        endcase
        we_d      = '0;
        rv_d      = accept;
        flush_d   = state_d != IDLE;
        badaddr_d = badaddr_q;
        epc_d     = epc_q;
        bd_d      = bd_q;
        code_d    = code_q;
        ien_d     = ien_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        rpc_d     = rpc_q;
        if (accept) begin
            ie_d  = Status_data[0];
            ien_d = Status_data[15:8];
            if (is_exc) begin
                we_d[14:12] = 3'b111;
                we_d[8]     = addr_err;
                exl_d       = 1'b1;
                epc_d       = mem_pc;
                bd_d        = mem_in_delay_slot;
                code_d      = code;
                rpc_d       = WIDTH'(EXC_VECTOR);
                // adel_if only wins the encoder when no interrupt is pending
                badaddr_d   = !addr_err ? '0 : (exc_adel_if && !int_pend) ? mem_pc : mem_badaddr;
            end else begin
                we_d[12] = 1'b1;
                exl_d    = 1'b0;
                rpc_d    = EPC_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            we_q      <= '0;
            rv_q      <= 1'b0;
            flush_q   <= 1'b0;
            badaddr_q <= '0;
            epc_q     <= '0;
            bd_q      <= 1'b0;
            code_q    <= '0;
            ien_q     <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            rpc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= {timer_int | hw_int[5], hw_int[4:0]};
            sync2_q   <= sync1_q;
            we_q      <= we_d;
            rv_q      <= rv_d;
            flush_q   <= flush_d;
            badaddr_q <= badaddr_d;
            epc_q     <= epc_d;
            bd_q      <= bd_d;
            code_q    <= code_d;
            ien_q     <= ien_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            rpc_q     <= rpc_d;
        end
    end

    assign we                    = we_q;
    assign BADADDR               = badaddr_q;
    assign epc                   = epc_q;
    assign Branch_delay          = bd_q;
    assign Exception_code        = code_q;
    assign hardware_interruption = sync2_q;
    assign interrupt_enable      = ien_q;
    assign EXL                   = exl_q;
    assign IE                    = ie_q;
    assign flush                 = flush_q;
    assign redirect_valid        = rv_q;
    assign redirect_pc           = rpc_q;
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'hBFC00380: general exception entry PC.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..7: cycles flush is held per event.
REQ-004 SHALL have ports, one per line, as follows.
clk  in  1  single clock; all state on rising edge
rst  in  1  reset, asynchronous and active-low (0 = reset)
mem_valid  in  1  MEM-stage instruction valid
mem_pc  in  WIDTH  MEM-stage instruction PC
mem_in_delay_slot  in  1  instruction sits in a branch delay slot
exc_adel_if  in  1  fetch address error
exc_ri  in  1  reserved instruction
exc_ov  in  1  arithmetic overflow
exc_sys  in  1  syscall
exc_bp  in  1  break
exc_adel_mem  in  1  load address error
exc_ades  in  1  store address error
is_eret  in  1  ERET in MEM
mem_badaddr  in  WIDTH  faulting data address
hw_int  in  6  asynchronous hardware interrupt lines
timer_int  in  1  CP0 timer interrupt
Status_data  in  WIDTH  CP0 Status
cause_data  in  WIDTH  CP0 Cause
EPC_data  in  WIDTH  CP0 EPC
we  out  WIDTH  CP0 per-register write enables
BADADDR  out  WIDTH  value for BadVAddr
epc  out  WIDTH  value for EPC (raw PC)
Branch_delay  out  1  delay-slot flag to CP0
Exception_code  out  5  ExcCode to CP0
hardware_interruption  out  6  synchronized interrupt lines to CP0
interrupt_enable  out  8  Status[15:8] write value
EXL  out  1  Status.EXL write value
IE  out  1  Status.IE write value
flush  out  1  kill all in-flight pipeline stages
redirect_valid  out  1  fetch redirect strobe
redirect_pc  out  WIDTH  fetch redirect target

Function
REQ-005 SHALL synchronize {timer_int|hw_int[5], hw_int[4:0]} through two flops; the second-flop value drives hardware_interruption.
REQ-006 SHALL compute int_pend = Status[0] & ~Status[1] & |(Status[15:8] & {sync_hw, cause_data[9:8]}).
REQ-007 SHALL accept an event only in state IDLE with mem_valid=1; otherwise inputs are ignored.
REQ-008 SHALL priority-encode, highest first, with ExcCode: int_pend 0, adel_if 4, ri 10, ov 12, sys 8, bp 9, adel_mem 4, ades 5, then is_eret; lower-priority flags are dropped.
REQ-009 SHALL register all outputs; event accepted at edge T drives outputs from T+1.
REQ-010 FSM states IDLE, COMMIT, FLUSH; IDLE->COMMIT on accepted event; COMMIT->FLUSH if FLUSH_CYCLES>1 else IDLE; FLUSH->IDLE after FLUSH_CYCLES-1 cycles (3-bit down-counter).
REQ-011 In COMMIT for an exception: we[12], we[13], we[14] = 1; we[8] = 1 only for codes 4/5; EXL=1; IE=Status[0]; interrupt_enable=Status[15:8]; epc=mem_pc; Branch_delay=mem_in_delay_slot; redirect_pc=EXC_VECTOR.
REQ-012 BADADDR SHALL be mem_pc for adel_if, mem_badaddr for adel_mem/ades, 0 otherwise.
REQ-013 In COMMIT for ERET: we[12] only; EXL=0; IE/interrupt_enable from Status_data; redirect_pc=EPC_data.
REQ-014 we and redirect_valid SHALL be high exactly one cycle (COMMIT); flush high in COMMIT and FLUSH, i.e. FLUSH_CYCLES cycles total.
REQ-015 Outside COMMIT, we=0, redirect_valid=0; data outputs hold last value.
REQ-016 Events arriving in COMMIT/FLUSH SHALL be dropped (flushed instruction); no queuing.

Reset
REQ-017 rst=0 SHALL immediately force state IDLE, counter 0, sync flops 0, all outputs 0 (redirect_pc=0), regardless of state, including mid-FLUSH.
REQ-018 First event SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-019 ov with mem_pc=0x80001000, slot=0 -> next cycle we=0x00007000, Exception_code=12, epc=0x80001000, redirect_pc=0xBFC00380, flush 2 cycles.
REQ-020 ades, mem_badaddr=0x80002003, slot=1 -> we=0x00007100, code 5, BADADDR=0x80002003, Branch_delay=1.
REQ-021 Status=0x0000FF01, hw_int[2] raised with ri -> code 0 two cycles after sync, ri dropped.
REQ-022 is_eret, EPC_data=0x80003000 -> we=0x00001000, EXL=0, redirect_pc=0x80003000.
REQ-023 sys then bp next cycle -> only sys committed; bp ignored during flush.
REQ-024 rst low during FLUSH -> flush=0 and we=0 immediately; new event accepted after release.
